// File: rtl/serial_ripple_subtractor.sv
// ----------------------------------------------------------------------------
// serial_ripple_subtractor
//
// Purpose:
//   Multi-cycle ripple-borrow subtractor computing diff = a - b - bin.
//   Each clock resolves BITS_PER_CYCLE bits, LSB slice first, through a
//   chain of full-subtractor bits.  The borrow out of one slice is held in
//   a register and feeds the next slice on the following cycle, so only a
//   BITS_PER_CYCLE-long combinational borrow chain exists.
//
// Parameters:
//   WIDTH           operand / result width (>= 2)
//   BITS_PER_CYCLE  bits resolved per clock; must divide WIDTH exactly
//
// Ports:
//   clk     in   1      clock, rising edge
//   rst     in   1      asynchronous active-high reset
//   start   in   1      request, accepted in IDLE or FIN only
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   bin     in   1      borrow-in, captured on accepted start
//   busy    out  1      high while an operation is in progress
//   done    out  1      one-cycle pulse; diff/borrow/ovf valid from here on
//   diff    out  WIDTH  result (held until the next completion)
//   borrow  out  1      borrow out of the MSB (unsigned a < b + bin)
//   ovf     out  1      signed overflow of the raw difference
//
// Optional feature (compile-time macro SUB_ABS_EN):
//   When defined, a negative raw result takes one extra NEG cycle that
//   replaces diff with its magnitude.  borrow still carries the raw sign and
//   ovf is still computed on the raw difference.
// ----------------------------------------------------------------------------
module serial_ripple_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int SAFE_BPC = (BITS_PER_CYCLE > 0) ? BITS_PER_CYCLE : 1;
    localparam int N        = WIDTH / SAFE_BPC;
    localparam int CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(N - 1);

    // Reject configurations where the slices would not tile the operand.
    generate
        if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % SAFE_BPC) != 0) begin : g_bad_params
            $error("serial_ripple_subtractor: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

`ifdef SUB_ABS_EN
    typedef enum logic [1:0] {IDLE, RUN, FIN, NEG} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
`endif

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic             brw_q,    brw_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    int                      slice_base;
    logic [SAFE_BPC-1:0]     slice_a;
    logic [SAFE_BPC-1:0]     slice_b;
    logic [SAFE_BPC-1:0]     slice_d;
    logic                    slice_bout;
    logic [WIDTH-1:0]        res_full;

    // Current slice: a ripple of full-subtractor bits seeded by the borrow
    // register.  res_full is the working result with this slice merged in,
    // which on the last slice is the complete raw difference.
    always_comb begin
        logic chain;
        slice_base = int'(cnt_q) * SAFE_BPC;
        slice_a    = a_q[slice_base +: SAFE_BPC];
        slice_b    = b_q[slice_base +: SAFE_BPC];
        slice_d    = '0;
        chain      = brw_q;
        for (int i = 0; i < SAFE_BPC; i++) begin
            slice_d[i] = slice_a[i] ^ slice_b[i] ^ chain;
            chain      = (~slice_a[i] & slice_b[i]) | (~(slice_a[i] ^ slice_b[i]) & chain);
        end
        slice_bout = chain;
        res_full   = res_q;
        res_full[slice_base +: SAFE_BPC] = slice_d;
    end

    // Next-state logic.  Result registers (diff/borrow/ovf) are only loaded on
    // the transition into FIN, so partial results are never visible.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d = res_full;
                brw_d = slice_bout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_SLICE) begin
                    cnt_d   = '0;
                    state_d = FIN;
                    diff_d   = res_full;
                    borrow_d = slice_bout;
                    ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_full[WIDTH-1]);
`ifdef SUB_ABS_EN
                    // Negative result: defer output load to NEG, which negates.
                    if (slice_bout) begin
                        state_d  = NEG;
                        diff_d   = diff_q;
                        borrow_d = borrow_q;
                        ovf_d    = ovf_q;
                    end
`endif
                end
            end
`ifdef SUB_ABS_EN
            NEG: begin
                state_d  = FIN;
                diff_d   = ~res_q + WIDTH'(1);
                borrow_d = brw_q;
                ovf_d    = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ res_q[WIDTH-1]);
            end
`endif
            default: state_d = IDLE;
        endcase

        // Status outputs are registered, so derive them from the next state.
        busy_d = (state_d == RUN);
`ifdef SUB_ABS_EN
        busy_d = busy_d | (state_d == NEG);
`endif
        done_d = (state_d == FIN);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// ----------------------------------------------------------------------------
// tb_serial_ripple_subtractor
//
// Directed bench for serial_ripple_subtractor.  u_dut is the 8-bit,
// 1-bit-per-cycle build; u_dut4 is the 8-bit, 4-bits-per-cycle build.
// Latencies are counted in cycles from the cycle in which start is high to
// the cycle in which done is high.
// ----------------------------------------------------------------------------
module tb_serial_ripple_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start4;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;

    logic       busy,  done,  borrow,  ovf;
    logic [7:0] diff;
    logic       busy4, done4, borrow4, ovf4;
    logic [7:0] diff4;

    int total = 0;
    int bad   = 0;
    int lat;
    int done_seen;

`ifdef SUB_ABS_EN
    localparam bit ABS = 1'b1;
`else
    localparam bit ABS = 1'b0;
`endif

    always #5 clk = ~clk;

    serial_ripple_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf)
    );

    serial_ripple_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk    (clk),
        .rst    (rst),
        .start  (start4),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy4),
        .done   (done4),
        .diff   (diff4),
        .borrow (borrow4),
        .ovf    (ovf4)
    );

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Hold start for one cycle with the given operands; returns 1 ns after
    // the accepting edge, i.e. in the first cycle after the start cycle.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 input logic binv, input logic use4);
        @(negedge clk);
        a   = av;
        b   = bv;
        bin = binv;
        if (use4) start4 = 1'b1;
        else      start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        start4 = 1'b0;
    endtask

    // Counts cycles until done is seen (bounded); called from the first
    // cycle after the start cycle, so the result is the done-cycle offset.
    task automatic waitDone(input logic use4, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(use4 ? done4 : done) && cycles < 40);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start4 = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        bin    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy",   busy,   1'b0);
        checkOutput("rst_done",   done,   1'b0);
        checkOutput("rst_diff",   diff,   8'h00);
        checkOutput("rst_borrow", borrow, 1'b0);
        checkOutput("rst_ovf",    ovf,    1'b0);
        rst = 1'b0;

        // 1: 0x05 - 0x03
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b0);
        checkOutput("t1_busy_run", busy, 1'b1);
        waitDone(1'b0, lat);
        checkOutput("t1_latency", lat,    9);
        checkOutput("t1_diff",    diff,   8'h02);
        checkOutput("t1_borrow",  borrow, 1'b0);
        checkOutput("t1_ovf",     ovf,    1'b0);
        checkOutput("t1_busy_fin", busy,  1'b0);
        @(negedge clk);
        checkOutput("t1_done_pulse", done, 1'b0);
        checkOutput("t1_diff_hold",  diff, 8'h02);

        // 2: 0x03 - 0x05 (negative result)
        applyStimulus(8'h03, 8'h05, 1'b0, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("t2_latency", lat,    ABS ? 10 : 9);
        checkOutput("t2_diff",    diff,   ABS ? 8'h02 : 8'hFE);
        checkOutput("t2_borrow",  borrow, 1'b1);
        checkOutput("t2_ovf",     ovf,    1'b0);

        // 3: 0x80 - 0x01, signed overflow
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("t3_latency", lat,    9);
        checkOutput("t3_diff",    diff,   8'h7F);
        checkOutput("t3_borrow",  borrow, 1'b0);
        checkOutput("t3_ovf",     ovf,    1'b1);

        // 4: start ignored while running, then back-to-back start in FIN
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        a     = 8'hFF;
        b     = 8'hFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("t4_busy_after_ignored", busy, 1'b1);
        waitDone(1'b0, lat);
        checkOutput("t4_done_seen", done,   1'b1);
        checkOutput("t4_diff",      diff,   8'h0F);
        checkOutput("t4_borrow",    borrow, 1'b0);
        a     = 8'h20;
        b     = 8'h05;
        bin   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("t4_b2b_busy",      busy, 1'b1);
        checkOutput("t4_b2b_done_low",  done, 1'b0);
        checkOutput("t4_b2b_diff_hold", diff, 8'h0F);
        waitDone(1'b0, lat);
        checkOutput("t4_b2b_latency", lat,    9);
        checkOutput("t4_b2b_diff",    diff,   8'h1A);
        checkOutput("t4_b2b_borrow",  borrow, 1'b0);

        // 5: reset in the middle of a run
        applyStimulus(8'h55, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t5_busy_abort", busy, 1'b0);
        checkOutput("t5_diff_abort", diff, 8'h00);
        checkOutput("t5_done_abort", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("t5_no_done", done_seen, 0);
        applyStimulus(8'h09, 8'h04, 1'b0, 1'b0);
        waitDone(1'b0, lat);
        checkOutput("t5_after_latency", lat,  9);
        checkOutput("t5_after_diff",    diff, 8'h05);

        // 6: 4 bits per cycle, 0x00 - 0x00 - 1 wraps to all-ones
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
        waitDone(1'b1, lat);
        checkOutput("t6_latency", lat,     ABS ? 4 : 3);
        checkOutput("t6_diff",    diff4,   ABS ? 8'h01 : 8'hFF);
        checkOutput("t6_borrow",  borrow4, 1'b1);
        checkOutput("t6_ovf",     ovf4,    1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
